// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared opcodes, control bit indices and step limits
// Used by the sequencer, its microcode ROM and the bench.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;

    localparam logic [2:0] LAST_FETCH = 3'd1;
    localparam logic [2:0] LAST_SHORT = 3'd2;
    localparam logic [2:0] LAST_MEM   = 3'd3;
    localparam logic [2:0] LAST_ALU   = 3'd4;

    typedef logic [15:0] ctrl_t;

    function automatic ctrl_t cbit(input int idx);
        return ctrl_t'(1) << idx;
    endfunction

    // Final microstep of each instruction; unknown opcodes end after fetch.
    function automatic logic [2:0] last_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA:                 return LAST_MEM;
            OP_ADD, OP_SUB:                 return LAST_ALU;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT:                 return LAST_SHORT;
            default:                        return LAST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// rtl/control_sequencer_microcode_rom.sv - combinational step/opcode to control word decode
// Ports: opcode, step, CF, ZF in; ctrl_raw (unmasked control word), last (final step) out.
module microcode_rom
    import control_sequencer_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  step,
    input  logic        CF,
    input  logic        ZF,
    output logic [15:0] ctrl_raw,
    output logic        last
);

    always_comb begin
        ctrl_raw = '0;
        // >= rather than == so a step past the opcode's end still wraps to fetch.
        last     = (step >= last_step(opcode));
        case (step)
            3'd0: ctrl_raw = cbit(B_CO) | cbit(B_MI);
            3'd1: ctrl_raw = cbit(B_RO) | cbit(B_II) | cbit(B_CE);
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_raw = cbit(B_IO) | cbit(B_MI);
                    OP_LDI: ctrl_raw = cbit(B_IO) | cbit(B_AI);
                    OP_JMP: ctrl_raw = cbit(B_IO) | cbit(B_J);
                    OP_JC:  ctrl_raw = CF ? (cbit(B_IO) | cbit(B_J)) : '0;
                    OP_JZ:  ctrl_raw = ZF ? (cbit(B_IO) | cbit(B_J)) : '0;
                    OP_OUT: ctrl_raw = cbit(B_AO) | cbit(B_OI);
                    OP_HLT: ctrl_raw = cbit(B_HLT);
                    default: ctrl_raw = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         ctrl_raw = cbit(B_RO) | cbit(B_AI);
                    OP_ADD, OP_SUB: ctrl_raw = cbit(B_RO) | cbit(B_BI);
                    OP_STA:         ctrl_raw = cbit(B_AO) | cbit(B_RI);
                    default:        ctrl_raw = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  ctrl_raw = cbit(B_EO) | cbit(B_AI);
                    OP_SUB:  ctrl_raw = cbit(B_EO) | cbit(B_SU) | cbit(B_AI);
                    default: ctrl_raw = '0;
                endcase
            end
            default: ctrl_raw = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microstep counter with halt latch and reset/halt overrides
// Ports: clk, rst (sync, active-high), opcode, CF, ZF in; ctrl, step, halted out.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        CF,
    input  logic        ZF,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    logic [2:0]  step_q, step_d;
    logic        halted_q, halted_d;
    logic [15:0] ctrl_raw;
    logic        last;

    microcode_rom u_rom (
        .opcode   (opcode),
        .step     (step_q),
        .CF       (CF),
        .ZF       (ZF),
        .ctrl_raw (ctrl_raw),
        .last     (last)
    );

    always_comb begin
        step_d   = step_q + 3'd1;
        halted_d = halted_q;
        if (halted_q) begin
            step_d = 3'd0;
        end else if (last) begin
            step_d = 3'd0;
            if (opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end

        // Reset dominates halt, which dominates the microcode.
        ctrl = ctrl_raw;
        if (rst) begin
            ctrl = '0;
        end else if (halted_q) begin
            ctrl = cbit(B_HLT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        cf, zf;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .CF     (cf),
        .ZF     (zf),
        .ctrl   (ctrl),
        .step   (step),
        .halted (halted)
    );

    // Reference: each opcode is a list of control words, one per cycle.
    logic [15:0] prog_w [16][5];
    int          prog_n [16];
    int          m_step;
    bit          m_halt;

    typedef struct {
        logic [3:0]  op;
        logic        c;
        logic        z;
        int          n;
        logic [15:0] w [5];
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic [3:0] op, input logic c, input logic z, input int n,
                                input logic [15:0] w0, w1, w2, w3, w4);
        vec_t v;
        v.op = op; v.c = c; v.z = z; v.n = n;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        return v;
    endfunction

    task automatic model_init();
        for (int op = 0; op < 16; op++) begin
            prog_n[op] = 2;
            prog_w[op][0] = 16'h4004;
            prog_w[op][1] = 16'h1408;
            for (int s = 2; s < 5; s++) prog_w[op][s] = 16'h0000;
        end
        prog_n[1]  = 4; prog_w[1][2]  = 16'h4800; prog_w[1][3] = 16'h1200;
        prog_n[2]  = 5; prog_w[2][2]  = 16'h4800; prog_w[2][3] = 16'h1020; prog_w[2][4] = 16'h0280;
        prog_n[3]  = 5; prog_w[3][2]  = 16'h4800; prog_w[3][3] = 16'h1020; prog_w[3][4] = 16'h02C0;
        prog_n[4]  = 4; prog_w[4][2]  = 16'h4800; prog_w[4][3] = 16'h2100;
        prog_n[5]  = 3; prog_w[5][2]  = 16'h0A00;
        prog_n[6]  = 3; prog_w[6][2]  = 16'h0802;
        prog_n[7]  = 3; prog_w[7][2]  = 16'h0802;
        prog_n[8]  = 3; prog_w[8][2]  = 16'h0802;
        prog_n[14] = 3; prog_w[14][2] = 16'h0110;
        prog_n[15] = 3; prog_w[15][2] = 16'h8000;
        m_step = 0;
        m_halt = 1'b0;
    endtask

    function automatic logic [15:0] model_ctrl(input logic r, input logic [3:0] op,
                                               input logic c, input logic z);
        if (r) return 16'h0000;
        if (m_halt) return 16'h8000;
        if (m_step >= prog_n[op]) return 16'h0000;
        if (m_step == 2 && ((op == 4'd7 && !c) || (op == 4'd8 && !z))) return 16'h0000;
        return prog_w[op][m_step];
    endfunction

    task automatic model_advance(input logic r, input logic [3:0] op);
        if (r) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            m_step = 0;
        end else if (m_step >= prog_n[op] - 1) begin
            if (op == 4'hF) m_halt = 1'b1;
            m_step = 0;
        end else begin
            m_step = m_step + 1;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the edge, sample mid-cycle, compare with model.
    task automatic run(input string nm, input logic r, input logic [3:0] op,
                       input logic c, input logic z);
        logic [15:0] e;
        @(posedge clk);
        #1;
        rst = r; opcode = op; cf = c; zf = z;
        #3;
        e = model_ctrl(r, op, c, z);
        chk({nm, " ctrl"}, ctrl, e);
        chk({nm, " step"}, {13'd0, step}, 16'(m_step));
        chk({nm, " halted"}, {15'd0, halted}, {15'd0, m_halt});
        model_advance(r, op);
    endtask

    logic [3:0] rop;
    logic       rr;

    initial begin
        rst = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
        model_init();

        tbl.push_back(mk(OP_ADD, 0, 0, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0280));
        tbl.push_back(mk(OP_SUB, 0, 0, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C0));
        tbl.push_back(mk(OP_LDA, 0, 0, 4, 16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000));
        tbl.push_back(mk(OP_STA, 1, 1, 4, 16'h4004, 16'h1408, 16'h4800, 16'h2100, 16'h0000));
        tbl.push_back(mk(OP_LDI, 0, 0, 3, 16'h4004, 16'h1408, 16'h0A00, 16'h0000, 16'h0000));
        tbl.push_back(mk(OP_JMP, 0, 0, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000));
        tbl.push_back(mk(OP_JC,  0, 1, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(OP_JC,  1, 0, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000));
        tbl.push_back(mk(OP_JZ,  1, 0, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(OP_JZ,  0, 1, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000));
        tbl.push_back(mk(OP_OUT, 0, 0, 3, 16'h4004, 16'h1408, 16'h0110, 16'h0000, 16'h0000));
        tbl.push_back(mk(OP_NOP, 0, 0, 2, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(4'hA,   0, 0, 2, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(4'hB,   1, 1, 2, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(OP_ADD, 0, 0, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0280));

        // Unchecked edge establishes a known state.
        @(posedge clk);

        // Reset held three cycles with ADD on the opcode lines.
        for (int i = 0; i < 3; i++) begin
            run("reset", 1'b1, OP_ADD, 1'b1, 1'b1);
            chk("reset ctrl zero", ctrl, 16'h0000);
        end

        // Table: each record is one full instruction; the next record's first
        // step check proves the previous one wrapped to 0 at the right time.
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].n; i++) begin
                run("tbl", 1'b0, tbl[k].op, tbl[k].c, tbl[k].z);
                chk($sformatf("tbl%0d op%h s%0d word", k, tbl[k].op, i), ctrl, tbl[k].w[i]);
                chk($sformatf("tbl%0d op%h s%0d step", k, tbl[k].op, i), {13'd0, step}, 16'(i));
            end
        end

        // JC sees a carry flag change within step 2 combinationally.
        run("jc_live", 1'b0, OP_JC, 1'b0, 1'b0);
        run("jc_live", 1'b0, OP_JC, 1'b0, 1'b0);
        run("jc_live", 1'b0, OP_JC, 1'b0, 1'b0);
        cf = 1'b1;
        #1;
        chk("jc live carry", ctrl, 16'h0802);

        // LDA interrupted by reset in step 3.
        run("lda_rst", 1'b0, OP_LDA, 1'b0, 1'b0);
        run("lda_rst", 1'b0, OP_LDA, 1'b0, 1'b0);
        run("lda_rst", 1'b0, OP_LDA, 1'b0, 1'b0);
        run("lda_rst", 1'b1, OP_LDA, 1'b0, 1'b0);
        chk("lda rst ctrl", ctrl, 16'h0000);
        run("lda_rst", 1'b0, OP_LDA, 1'b0, 1'b0);
        chk("lda after rst ctrl", ctrl, 16'h4004);
        chk("lda after rst step", {13'd0, step}, 16'd0);
        for (int i = 1; i < 4; i++) run("lda_rst", 1'b0, OP_LDA, 1'b0, 1'b0);

        // HLT, then 20 frozen cycles with noisy inputs, then reset recovery.
        run("hlt", 1'b0, OP_HLT, 1'b0, 1'b0);
        run("hlt", 1'b0, OP_HLT, 1'b0, 1'b0);
        run("hlt", 1'b0, OP_HLT, 1'b0, 1'b0);
        chk("hlt step2 ctrl", ctrl, 16'h8000);
        chk("hlt step2 not yet halted", {15'd0, halted}, 16'd0);
        for (int i = 0; i < 20; i++) begin
            run("halted", 1'b0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
            chk("halted flag", {15'd0, halted}, 16'd1);
            chk("halted ctrl", ctrl, 16'h8000);
            chk("halted step", {13'd0, step}, 16'd0);
        end
        run("hlt_rst", 1'b1, OP_ADD, 1'b0, 1'b0);
        chk("hlt rst ctrl", ctrl, 16'h0000);
        run("hlt_rst", 1'b0, OP_ADD, 1'b0, 1'b0);
        chk("hlt cleared", {15'd0, halted}, 16'd0);
        chk("hlt cleared ctrl", ctrl, 16'h4004);
        for (int i = 1; i < 5; i++) run("hlt_rst", 1'b0, OP_ADD, 1'b0, 1'b0);

        // Random instruction stream against the reference model.
        rop = OP_NOP;
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            if (m_step == 0 && !m_halt) rop = 4'($urandom_range(0, 15));
            run("rand", rr, rop, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
